// File: rtl/quad_encoder_decoder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// quad_encoder_decoder_if : encoder pins, homing/error requests and angle outputs
// Rev 1.0
// -----------------------------------------------------------------------------
interface quad_encoder_decoder_if #(
  parameter int ANGLE_W = 12
);
  logic               enc_a;
  logic               enc_b;
  logic               enc_index;
  logic               zero_req;
  logic               err_clr;
  logic [ANGLE_W-1:0] angle;
  logic               direction;
  logic               step_valid;
  logic               quad_err;
  logic               homed;

  modport master (
    output enc_a, enc_b, enc_index, zero_req, err_clr,
    input  angle, direction, step_valid, quad_err, homed
  );

  modport slave (
    input  enc_a, enc_b, enc_index, zero_req, err_clr,
    output angle, direction, step_valid, quad_err, homed
  );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_decoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// quad_encoder_decoder : x4 A/B quadrature decode into a wrapped shaft angle;
// define ENC_INDEX_HOME_EN to home on the index rising edge.  Rev 1.0
// -----------------------------------------------------------------------------
module quad_encoder_decoder #(
  parameter int COUNTS_PER_REV = 1006,
  parameter int ANGLE_W        = 12,
  parameter int SYNC_STAGES    = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  quad_encoder_decoder_if.slave bus
);
  localparam int                 PCW          = $clog2(SYNC_STAGES + 1);
  localparam logic [ANGLE_W-1:0] C_ANGLE_MAX  = ANGLE_W'(COUNTS_PER_REV - 1);
  localparam logic [PCW-1:0]     C_PRIME_LAST = PCW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             r_prev;
  logic                   r_primed;
  logic [PCW-1:0]         r_prime_cnt;
  logic [ANGLE_W-1:0]     r_angle;
  logic                   r_direction;
  logic                   r_step_valid;
  logic                   r_quad_err;
  logic                   r_homed;

  logic [1:0] w_cur;
  logic [1:0] w_delta;
  logic       w_load_prev;
  logic       w_cw;
  logic       w_acw;
  logic       w_illegal;
  logic       w_home;

  // Gray {A,B} to phase 0..3 along the cw sequence; phase difference mod 4 gives the step.
  function automatic logic [1:0] f_phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  assign w_cur       = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  assign w_delta     = f_phase(w_cur) - f_phase(r_prev);
  assign w_load_prev = r_primed || (r_prime_cnt == C_PRIME_LAST);
  assign w_cw        = r_primed && (w_delta == 2'd1);
  assign w_acw       = r_primed && (w_delta == 2'd3);
  assign w_illegal   = r_primed && (w_delta == 2'd2);

`ifdef ENC_INDEX_HOME_EN
  logic [SYNC_STAGES-1:0] r_sync_idx;
  logic                   r_idx_prev;
  logic                   w_idx_rise;

  assign w_idx_rise = r_primed && r_sync_idx[SYNC_STAGES-1] && !r_idx_prev;
  assign w_home     = bus.zero_req || w_idx_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync_idx <= '0;
      r_idx_prev <= 1'b0;
    end else begin
      r_sync_idx <= {r_sync_idx[SYNC_STAGES-2:0], bus.enc_index};
      if (w_load_prev) r_idx_prev <= r_sync_idx[SYNC_STAGES-1];
    end
  end
`else
  logic w_unused_index;
  assign w_unused_index = bus.enc_index;
  assign w_home         = bus.zero_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync_a     <= '0;
      r_sync_b     <= '0;
      r_prev       <= 2'b00;
      r_primed     <= 1'b0;
      r_prime_cnt  <= '0;
      r_angle      <= '0;
      r_direction  <= 1'b0;
      r_step_valid <= 1'b0;
      r_quad_err   <= 1'b0;
      r_homed      <= 1'b0;
    end else begin
      r_sync_a     <= {r_sync_a[SYNC_STAGES-2:0], bus.enc_a};
      r_sync_b     <= {r_sync_b[SYNC_STAGES-2:0], bus.enc_b};
      r_step_valid <= 1'b0;

      // The last priming cycle seeds prev from already-synchronised pins.
      if (w_load_prev) r_prev <= w_cur;
      if (!r_primed) begin
        if (r_prime_cnt == C_PRIME_LAST) r_primed    <= 1'b1;
        else                             r_prime_cnt <= r_prime_cnt + PCW'(1);
      end

      if (w_illegal)        r_quad_err <= 1'b1;
      else if (bus.err_clr) r_quad_err <= 1'b0;

      if (w_home) begin
        r_angle <= '0;
        r_homed <= 1'b1;
      end else if (w_cw) begin
        r_angle      <= (r_angle == C_ANGLE_MAX) ? '0 : r_angle + ANGLE_W'(1);
        r_direction  <= 1'b1;
        r_step_valid <= 1'b1;
      end else if (w_acw) begin
        r_angle      <= (r_angle == '0) ? C_ANGLE_MAX : r_angle - ANGLE_W'(1);
        r_direction  <= 1'b0;
        r_step_valid <= 1'b1;
      end
    end
  end

  assign bus.angle      = r_angle;
  assign bus.direction  = r_direction;
  assign bus.step_valid = r_step_valid;
  assign bus.quad_err   = r_quad_err;
  assign bus.homed      = r_homed;
endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_decoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_quad_encoder_decoder : directed scenarios plus random walk against a
// cycle-level reference model of the quadrature decoder.  Rev 1.0
// -----------------------------------------------------------------------------
module tb_quad_encoder_decoder;
  localparam int CPR = 1006;
  localparam int AW  = 12;
  localparam int SS  = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  quad_encoder_decoder_if #(.ANGLE_W(AW)) bus ();

  quad_encoder_decoder #(
    .COUNTS_PER_REV(CPR),
    .ANGLE_W       (AW),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // cw order of {A,B}
  logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int seq_pos(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (cw_seq[i] == v) return i;
    return 0;
  endfunction

  // Reference model: pins seen at each edge, replayed SS edges later.
  int         m_angle, m_dir, m_sv, m_err, m_homed, m_cyc;
  logic [1:0] ab_d  [SS+2];
  logic       idx_d [SS+2];

  logic [1:0] pin_ab  = 2'b00;
  logic       pin_idx = 1'b0;

  task automatic model_step(input logic rn, input logic zr, input logic ec);
    int  delta;
    bit  home;
    if (!rn) begin
      m_angle = 0; m_dir = 0; m_sv = 0; m_err = 0; m_homed = 0; m_cyc = 0;
      for (int i = 0; i < SS + 2; i++) begin ab_d[i] = 2'b00; idx_d[i] = 1'b0; end
      return;
    end
    m_cyc++;
    for (int i = SS + 1; i > 0; i--) begin ab_d[i] = ab_d[i-1]; idx_d[i] = idx_d[i-1]; end
    ab_d[0]  = pin_ab;
    idx_d[0] = pin_idx;
    delta = 0;
    home  = zr;
    if (m_cyc >= SS + 2) begin
      delta = (seq_pos(ab_d[SS]) - seq_pos(ab_d[SS+1]) + 4) % 4;
`ifdef ENC_INDEX_HOME_EN
      if (idx_d[SS] && !idx_d[SS+1]) home = 1'b1;
`endif
    end
    m_sv = 0;
    if (delta == 2)  m_err = 1;
    else if (ec)     m_err = 0;
    if (home) begin
      m_angle = 0;
      m_homed = 1;
    end else if (delta == 1) begin
      m_angle = (m_angle + 1) % CPR;
      m_dir   = 1;
      m_sv    = 1;
    end else if (delta == 3) begin
      m_angle = (m_angle + CPR - 1) % CPR;
      m_dir   = 0;
      m_sv    = 1;
    end
  endtask

  task automatic tick(input logic rn, input logic zr, input logic ec);
    reset_n       = rn;
    bus.enc_a     = pin_ab[1];
    bus.enc_b     = pin_ab[0];
    bus.enc_index = pin_idx;
    bus.zero_req  = zr;
    bus.err_clr   = ec;
    @(posedge clk);
    model_step(rn, zr, ec);
    #1;
    check_eq("angle",      bus.angle,      m_angle);
    check_eq("direction",  bus.direction,  m_dir);
    check_eq("step_valid", bus.step_valid, m_sv);
    check_eq("quad_err",   bus.quad_err,   m_err);
    check_eq("homed",      bus.homed,      m_homed);
  endtask

  task automatic step_cw();
    pin_ab = cw_seq[(seq_pos(pin_ab) + 1) % 4];
  endtask

  task automatic step_acw();
    pin_ab = cw_seq[(seq_pos(pin_ab) + 3) % 4];
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic walk_cw(input int n);
    repeat (n) begin step_cw(); idle(2); end
    idle(SS + 2);
  endtask

  initial begin
    int pulses;
    int r;

    // Reset with both pins high, then priming must stay silent.
    pin_ab = 2'b11;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check_eq("rst_angle", bus.angle, 0);
    check_eq("rst_homed", bus.homed, 0);
    pulses = 0;
    repeat (6) begin tick(1'b1, 1'b0, 1'b0); pulses += int'(bus.step_valid); end
    check_eq("prime_err",    bus.quad_err, 0);
    check_eq("prime_pulses", pulses, 0);

    // Five cw steps, each pulse SS+1 cycles after its pin change.
    pin_ab = 2'b00;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    idle(4);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step_cw();
      for (int j = 0; j < 4; j++) begin
        tick(1'b1, 1'b0, 1'b0);
        pulses += int'(bus.step_valid);
        check_eq("lat_pulse", bus.step_valid, (j == SS) ? 1 : 0);
      end
    end
    check_eq("cw5_angle",  bus.angle, 5);
    check_eq("cw5_dir",    bus.direction, 1);
    check_eq("cw5_pulses", pulses, 5);

    // Wrap in both directions.
    tick(1'b1, 1'b1, 1'b0);
    step_acw(); idle(SS + 2);
    check_eq("wrap_dn_angle", bus.angle, CPR - 1);
    step_cw();  idle(SS + 2);
    check_eq("wrap_up_angle", bus.angle, 0);
    step_acw(); idle(SS + 2);
    check_eq("wrap_dn2_angle", bus.angle, CPR - 1);
    check_eq("wrap_dn2_dir",   bus.direction, 0);

    // Illegal transition coincident with err_clr: set wins.
    pin_ab = ~pin_ab;
    idle(SS);
    tick(1'b1, 1'b0, 1'b1);
    check_eq("ill_err",   bus.quad_err, 1);
    check_eq("ill_angle", bus.angle, CPR - 1);
    tick(1'b1, 1'b0, 1'b1);
    check_eq("clr_err", bus.quad_err, 0);

    // zero_req swallows a coincident step.
    tick(1'b1, 1'b1, 1'b0);
    walk_cw(300);
    check_eq("at300", bus.angle, 300);
    step_cw();
    idle(SS);
    tick(1'b1, 1'b1, 1'b0);
    check_eq("zr_angle", bus.angle, 0);
    check_eq("zr_sv",    bus.step_valid, 0);
    check_eq("zr_homed", bus.homed, 1);
    idle(2);
    walk_cw(1);
    check_eq("zr_next", bus.angle, 1);

    // Index rising edge at 777.
    tick(1'b1, 1'b1, 1'b0);
    walk_cw(777);
    check_eq("at777", bus.angle, 777);
    pin_idx = 1'b1;
    idle(SS + 2);
    pin_idx = 1'b0;
`ifdef ENC_INDEX_HOME_EN
    check_eq("idx_angle", bus.angle, 0);
`else
    check_eq("idx_angle", bus.angle, 777);
`endif

    // Random walk with occasional illegal jumps, requests and resets.
    for (int it = 0; it < 2500; it++) begin
      r = int'($urandom_range(0, 15));
      if (r < 6)       step_cw();
      else if (r < 12) step_acw();
      else if (r == 14) pin_ab = ~pin_ab;
      if ($urandom_range(0, 9) == 0) pin_idx = ~pin_idx;
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
      tick(1'b1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
